datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
- Execution-side responder to the control unit. Consumes operand1/operand2/offset/opcode/sel1/sel3/w_r each cycle and returns result2.
- Contains a registered ALU stage, a 2^ADDR_BITS x DATA_WIDTH synchronous data memory, and a result mux.
- Tracks store events for debug and bench use.
- Sits between the control unit outputs and the control unit's result2 input.

Parameters:
- DATA_WIDTH, 8, data/operand width
- ADDR_BITS, 5, data memory address width (32 words)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- operand1  in  DATA_WIDTH  ALU A / memory base address
- operand2  in  DATA_WIDTH  ALU B / store data
- offset  in  DATA_WIDTH  address offset / immediate
- opcode  in  4  ALU operation
- sel1  in  1  1 = result2 from ALU, 0 = result2 from memory
- sel3  in  1  1 = B is offset and memory address is operand1+offset
- w_r  in  1  1 = write operand2 to memory
- result2  out  DATA_WIDTH  registered result back to control unit
- store_cnt  out  8  count of store events, saturating
- flags  out  3  {carry, zero, overflow} of last ALU op

Behaviour:
- Reset: all actions happen on the rising clk edge while rst==0.
  - Clears the ALU register, memory read register, sel1 pipe, result2, store_cnt, flags and w_r history to 0.
  - Clears every memory word to 0.
  - A write requested in the same cycle is dropped.
  - Reset has priority over all other actions, including mid-operation.
- ALU input: A=operand1; B = sel3 ? offset : operand2.
- ALU operations (registered into alu_q each cycle):
  - 0000 A+B; 0001 A-B; 0010 A&B; 0011 A|B; 0100 A^B; 0101 ~A
  - 0110 A<<B[2:0]; 0111 A>>B[2:0] (logical)
  - 1000 A; 1001 B; 1010 A+1; 1011 A-1; 1100 (A<B unsigned)?1:0
  - 1111 NOP: alu_q and flags hold
  - all other opcodes: alu_q=0
  - Results truncated to DATA_WIDTH; wrap-around permitted.
- Effective address: ea = (operand1+offset) mod 2^ADDR_BITS, computed regardless of opcode. Upper bits are discarded (wrap, no fault).
- Memory write: when w_r==1, mem[ea] <= operand2 at the clock edge. Repeated identical writes across consecutive cycles are harmless.
- Memory read: mem_q <= mem[ea] every cycle. When reading and writing the same address in the same cycle, the old data is returned (read-first).
- Output:
  - sel1_q <= sel1.
  - result2 = sel1_q ? alu_q : mem_q.
  - Latency is exactly 1 cycle from input change to result2. Inputs held for ≥2 cycles give a stable result2 from cycle 2 onward.
- store_cnt: increments by 1 on each 0->1 transition of w_r (edge-detected against a registered copy of w_r). A multi-cycle w_r pulse counts once. Saturates at 255.
- Flags: computed from the same op as alu_q and updated alongside it.
  - zero = (result==0).
  - carry = carry-out for 0000/1010, borrow for 0001/1011, else 0.
  - overflow = signed overflow for add/sub forms, else 0.

Optional Feature:
- Macro: DP_FLAGS_EN.
- Defined: flags register and logic present as described.
- Undefined: no flag logic; flags output tied to 3'b000.
- All other behaviour is identical in both cases.

Test Plan:
- Reset: rst=0 for 1 cycle with w_r=1, operand1=3, operand2=0x55 -> result2=0, store_cnt=0, mem[3] still 0 after reset is released.
- ALU add: operand1=1, operand2=2, opcode=0000, sel1=1, sel3=0 -> result2=3 one cycle later. Then operand1=0xFF, operand2=0x01 -> result2=0x00, flags=3'b110 (carry, zero).
- Store held for 4 cycles: operand1=2, offset=4, operand2=0xA5, w_r=1, sel1=1, sel3=1 -> mem[6]=0xA5, store_cnt=1 (not 4).
- Load: w_r=0, sel1=0, sel3=1, operand1=2, offset=4 -> result2=0xA5 one cycle later.
- Address wrap: operand1=30, offset=5 -> store to mem[3]. Reading back with operand1=0, offset=3 -> 0x… equal to the stored value.
- Read-during-write: mem[6]=0xA5, then a write of 0x3C to ea=6 with sel1=0 -> result2=0xA5 next cycle and 0x3C the cycle after.

Source files
------------

// File: rtl/datapath_unit.sv
// Execution-side datapath: registered ALU, 32-word synchronous data memory, result mux
// and store-event counter. Flag logic is present only when DP_FLAGS_EN is defined.
module datapath_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic [7:0]            store_cnt,
  output logic [2:0]            flags
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int MSB   = DATA_WIDTH - 1;
  localparam logic [3:0] OP_NOP = 4'b1111;
  localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] b_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic [ADDR_BITS-1:0]  ea_s;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  sel1_q;
  logic                  w_r_q;

  function automatic logic [DATA_WIDTH-1:0] alu_result(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] res;
    res = ZERO;
    case (op)
      4'b0000: res = a + b;
      4'b0001: res = a - b;
      4'b0010: res = a & b;
      4'b0011: res = a | b;
      4'b0100: res = a ^ b;
      4'b0101: res = ~a;
      4'b0110: res = a << b[2:0];
      4'b0111: res = a >> b[2:0];
      4'b1000: res = a;
      4'b1001: res = b;
      4'b1010: res = a + ONE;
      4'b1011: res = a - ONE;
      4'b1100: res = (a < b) ? ONE : ZERO;
      default: res = ZERO;
    endcase
    return res;
  endfunction

  // ALU operand select and effective address; the narrow add wraps modulo the memory depth
  always_comb begin
    b_s       = sel3 ? offset : operand2;
    ea_s      = operand1[ADDR_BITS-1:0] + offset[ADDR_BITS-1:0];
    alu_res_s = alu_result(opcode, operand1, b_s);
  end

  // ALU result register and result-source pipe; NOP leaves alu_q untouched
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_q  <= ZERO;
      sel1_q <= 1'b0;
    end else begin
      sel1_q <= sel1;
      if (opcode != OP_NOP) begin
        alu_q <= alu_res_s;
      end
    end
  end

  // Data memory: read-first, and reset wipes every word and drops a concurrent write
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ZERO;
      end
      mem_q <= ZERO;
    end else begin
      if (w_r) begin
        mem[ea_s] <= operand2;
      end
      mem_q <= mem[ea_s];
    end
  end

  // Store counter counts rising edges of w_r only and sticks at its maximum
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_r_q     <= 1'b0;
      store_cnt <= 8'd0;
    end else begin
      w_r_q <= w_r;
      if (w_r && !w_r_q && (store_cnt != 8'hFF)) begin
        store_cnt <= store_cnt + 8'd1;
      end
    end
  end

  assign result2 = sel1_q ? alu_q : mem_q;

`ifdef DP_FLAGS_EN
  logic [2:0] flags_q;

  function automatic logic [2:0] alu_flags(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] res
  );
    logic [DATA_WIDTH:0] wide;
    logic c;
    logic v;
    wide = {(DATA_WIDTH+1){1'b0}};
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[DATA_WIDTH];
        v    = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      4'b0001: begin
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[DATA_WIDTH];
        v    = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      4'b1010: begin
        wide = {1'b0, a} + {1'b0, ONE};
        c    = wide[DATA_WIDTH];
        v    = !a[MSB] && res[MSB];
      end
      4'b1011: begin
        wide = {1'b0, a} - {1'b0, ONE};
        c    = wide[DATA_WIDTH];
        v    = a[MSB] && !res[MSB];
      end
      default: begin
        c = 1'b0;
        v = 1'b0;
      end
    endcase
    return {c, (res == ZERO), v};
  endfunction

  // Flags follow alu_q: same op, same hold on NOP
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= 3'b000;
    end else if (opcode != OP_NOP) begin
      flags_q <= alu_flags(opcode, operand1, b_s, alu_res_s);
    end
  end

  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: integer-arithmetic reference model with a
// per-cycle comparator, plus directed vectors carrying hand-computed literal expectations.
module tb_datapath_unit;

`ifdef DP_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] offset;
  logic [3:0] opcode;
  logic       sel1;
  logic       sel3;
  logic       w_r;
  logic [7:0] result2;
  logic [7:0] store_cnt;
  logic [2:0] flags;

  int checks = 0;
  int errors = 0;

  datapath_unit #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2), .offset(offset),
    .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
    .result2(result2), .store_cnt(store_cnt), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mem_m [32];
  logic [7:0] alu_m;
  logic [2:0] fl_m;
  logic [7:0] exp_res;
  int         cnt_m;
  bit         prev_w;
  bit         model_ok = 1'b0;
  int ma, mb, mr, sa, sb, ms, ea;
  bit mc, mv;

  // Model advances on every rising edge from the inputs held stable since the last negedge
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
      alu_m = 8'h00; fl_m = 3'b000; exp_res = 8'h00;
      cnt_m = 0; prev_w = 1'b0; model_ok = 1'b1;
    end else begin
      ma = int'(operand1);
      mb = sel3 ? int'(offset) : int'(operand2);
      sa = (ma >= 128) ? ma - 256 : ma;
      sb = (mb >= 128) ? mb - 256 : mb;
      mc = 1'b0; mv = 1'b0; mr = 0;
      case (opcode)
        4'd0:  begin mr = ma + mb; mc = (mr > 255); ms = sa + sb; mv = (ms > 127) || (ms < -128); end
        4'd1:  begin mr = ma - mb; mc = (ma < mb);  ms = sa - sb; mv = (ms > 127) || (ms < -128); end
        4'd2:  mr = ma & mb;
        4'd3:  mr = ma | mb;
        4'd4:  mr = ma ^ mb;
        4'd5:  mr = 255 - ma;
        4'd6:  mr = ma << (mb % 8);
        4'd7:  mr = ma >> (mb % 8);
        4'd8:  mr = ma;
        4'd9:  mr = mb;
        4'd10: begin mr = ma + 1; mc = (mr > 255); mv = (sa + 1 > 127); end
        4'd11: begin mr = ma - 1; mc = (ma == 0);  mv = (sa - 1 < -128); end
        4'd12: mr = (ma < mb) ? 1 : 0;
        default: mr = 0;
      endcase
      if (opcode != 4'd15) begin
        alu_m = mr[7:0];
        fl_m  = {mc, (mr[7:0] == 8'h00), mv};
      end
      ea = (int'(operand1) + int'(offset)) % 32;
      exp_res = sel1 ? alu_m : mem_m[ea];
      if (w_r) mem_m[ea] = operand2;
      if (w_r && !prev_w && cnt_m < 255) cnt_m++;
      prev_w = w_r;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (result2 !== exp_res) begin
        errors++;
        $display("FAIL model_result2 t=%0t: got %h expected %h", $time, result2, exp_res);
      end
      checks++;
      if (store_cnt !== 8'(cnt_m)) begin
        errors++;
        $display("FAIL model_store_cnt t=%0t: got %0d expected %0d", $time, store_cnt, cnt_m);
      end
      checks++;
      if (flags !== (FLAGS_EN ? fl_m : 3'b000)) begin
        errors++;
        $display("FAIL model_flags t=%0t: got %b expected %b", $time, flags, FLAGS_EN ? fl_m : 3'b000);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at a negedge and return at the next negedge with the result visible
  task automatic apply(input logic r, input logic [7:0] o1, input logic [7:0] o2,
                       input logic [7:0] off, input logic [3:0] opc,
                       input logic s1, input logic s3, input logic wr);
    rst = r; operand1 = o1; operand2 = o2; offset = off;
    opcode = opc; sel1 = s1; sel3 = s3; w_r = wr;
    @(negedge clk);
  endtask

  logic [7:0] pa [5];
  logic [7:0] pb [5];

  initial begin
    rst = 1'b1; operand1 = 8'h00; operand2 = 8'h00; offset = 8'h00;
    opcode = 4'h0; sel1 = 1'b0; sel3 = 1'b0; w_r = 1'b0;
    pa[0] = 8'h7F; pb[0] = 8'h01;
    pa[1] = 8'h80; pb[1] = 8'h01;
    pa[2] = 8'h00; pb[2] = 8'h01;
    pa[3] = 8'h5A; pb[3] = 8'h03;
    pa[4] = 8'h10; pb[4] = 8'h20;
    @(negedge clk);

    // Reset with a write pending: write dropped, everything zero
    apply(1'b0, 8'd3, 8'h55, 8'd0, 4'h0, 1'b1, 1'b0, 1'b1);
    lit("reset_result2", result2, 8'h00);
    lit("reset_store_cnt", store_cnt, 8'd0);
    lit("reset_flags", {5'd0, flags}, 8'h00);
    apply(1'b1, 8'd3, 8'h00, 8'd0, 4'h8, 1'b0, 1'b1, 1'b0);
    lit("reset_mem3", result2, 8'h00);

    // ALU add and its carry/zero case
    apply(1'b1, 8'd1, 8'd2, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    lit("add_1_2", result2, 8'h03);
    apply(1'b1, 8'hFF, 8'h01, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    lit("add_ff_01", result2, 8'h00);
    lit("add_ff_01_flags", {5'd0, flags}, FLAGS_EN ? 8'h06 : 8'h00);
    apply(1'b1, 8'h7F, 8'h01, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    lit("add_7f_01", result2, 8'h80);
    lit("add_7f_01_flags", {5'd0, flags}, FLAGS_EN ? 8'h01 : 8'h00);
    apply(1'b1, 8'h10, 8'h20, 8'd0, 4'h1, 1'b1, 1'b0, 1'b0);
    lit("sub_10_20", result2, 8'hF0);
    lit("sub_10_20_flags", {5'd0, flags}, FLAGS_EN ? 8'h04 : 8'h00);
    apply(1'b1, 8'h5A, 8'h03, 8'd0, 4'h6, 1'b1, 1'b0, 1'b0);
    lit("shl_5a_3", result2, 8'hD0);
    apply(1'b1, 8'h5A, 8'h00, 8'd3, 4'h7, 1'b1, 1'b1, 1'b0);
    lit("shr_5a_imm3", result2, 8'h0B);
    apply(1'b1, 8'd3, 8'd5, 8'd0, 4'hC, 1'b1, 1'b0, 1'b0);
    lit("ult_3_5", result2, 8'h01);

    // NOP holds the previous ALU result
    apply(1'b1, 8'd5, 8'd6, 8'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    lit("add_5_6", result2, 8'h0B);
    apply(1'b1, 8'h40, 8'h40, 8'd0, 4'hF, 1'b1, 1'b0, 1'b0);
    lit("nop_hold", result2, 8'h0B);

    // Store held for four cycles counts once
    for (int i = 0; i < 4; i++) apply(1'b1, 8'd2, 8'hA5, 8'd4, 4'h0, 1'b1, 1'b1, 1'b1);
    lit("store_held_cnt", store_cnt, 8'd1);
    apply(1'b1, 8'd2, 8'h00, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0);
    lit("load_mem6", result2, 8'hA5);

    // Address wrap: 30+5 lands on word 3
    apply(1'b1, 8'd30, 8'h77, 8'd5, 4'h0, 1'b1, 1'b1, 1'b1);
    apply(1'b1, 8'd0, 8'h00, 8'd3, 4'h0, 1'b0, 1'b1, 1'b0);
    lit("wrap_load_mem3", result2, 8'h77);
    lit("wrap_store_cnt", store_cnt, 8'd2);

    // Read during write returns old data, new data one cycle later
    apply(1'b1, 8'd2, 8'h3C, 8'd4, 4'h0, 1'b0, 1'b1, 1'b1);
    lit("rdw_old", result2, 8'hA5);
    apply(1'b1, 8'd2, 8'h3C, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0);
    lit("rdw_new", result2, 8'h3C);

    // Opcode sweep over operand patterns, both B sources
    for (int op = 0; op < 16; op++)
      for (int p = 0; p < 5; p++)
        for (int s = 0; s < 2; s++)
          apply(1'b1, pa[p], pb[p], pb[p] ^ 8'h33, 4'(op), (op % 3) != 0, s[0], 1'b0);

    // Saturate the store counter
    for (int i = 0; i < 260; i++) begin
      apply(1'b1, 8'd10, 8'(i), 8'd0, 4'h8, 1'b0, 1'b0, 1'b1);
      apply(1'b1, 8'd10, 8'h00, 8'd0, 4'h8, 1'b0, 1'b0, 1'b0);
    end
    lit("store_cnt_sat", store_cnt, 8'hFF);

    // Mid-operation reset wipes memory and drops the pending write
    apply(1'b1, 8'd6, 8'h99, 8'd0, 4'h0, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 8'd6, 8'h99, 8'd0, 4'h0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 8'd2, 8'h00, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0);
    lit("midreset_mem6", result2, 8'h00);
    lit("midreset_cnt", store_cnt, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
